// File: rtl/video_timing_gen.sv
// video_timing_gen: strobe-paced raster timing generator with registered coordinates, syncs, DE and frame markers
module video_timing_gen #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter bit SYNC_POL = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_pix_stb,
    output logic [15:0] o_x,
    output logic [15:0] o_y,
    output logic        o_h_sync,
    output logic        o_v_sync,
    output logic        o_de,
    output logic        o_line_start,
    output logic        o_frame_start,
    output logic        o_vblank_start,
    output logic [15:0] o_frame_count
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [15:0] H_A    = 16'(H_ACTIVE);
    localparam logic [15:0] H_SS   = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] H_SE   = 16'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [15:0] H_LAST = 16'(H_TOTAL - 1);
    localparam logic [15:0] V_A    = 16'(V_ACTIVE);
    localparam logic [15:0] V_SS   = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] V_SE   = 16'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [15:0] V_LAST = 16'(V_TOTAL - 1);

    generate
        if (H_TOTAL > 65535 || V_TOTAL > 65535 || H_SYNC < 1 || V_SYNC < 1 || H_ACTIVE < 1 || V_ACTIVE < 1) begin : g_bad_timing
            $error("video_timing_gen: invalid timing parameters");
        end
    endgenerate

    logic [15:0] nx, ny, nx_next, ny_next;
    logic        h_wrap, first;

    // Advance the next-pixel position, wrapping at the end of line and frame
    always_comb begin
        h_wrap  = nx == H_LAST;
        nx_next = h_wrap ? 16'd0 : nx + 16'd1;
        ny_next = !h_wrap ? ny : (ny == V_LAST) ? 16'd0 : ny + 16'd1;
    end

    // Emit the decoded state of position (nx,ny) on each strobe; pulses last one clock
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            nx             <= 16'd0;
            ny             <= 16'd0;
            o_x            <= 16'd0;
            o_y            <= 16'd0;
            o_h_sync       <= ~SYNC_POL;
            o_v_sync       <= ~SYNC_POL;
            o_de           <= 1'b0;
            o_line_start   <= 1'b0;
            o_frame_start  <= 1'b0;
            o_vblank_start <= 1'b0;
            o_frame_count  <= 16'd0;
            first          <= 1'b1;
        end else begin
            o_line_start   <= 1'b0;
            o_frame_start  <= 1'b0;
            o_vblank_start <= 1'b0;
            if (i_pix_stb) begin
                nx             <= nx_next;
                ny             <= ny_next;
                o_x            <= nx;
                o_y            <= ny;
                o_h_sync       <= (nx >= H_SS && nx < H_SE) ? SYNC_POL : ~SYNC_POL;
                o_v_sync       <= (ny >= V_SS && ny < V_SE) ? SYNC_POL : ~SYNC_POL;
                o_de           <= nx < H_A && ny < V_A;
                o_line_start   <= nx == 16'd0;
                o_frame_start  <= nx == 16'd0 && ny == 16'd0;
                o_vblank_start <= nx == 16'd0 && ny == V_A;
                if (nx == 16'd0 && ny == 16'd0) begin
                    first <= 1'b0;
                    if (!first)
                        o_frame_count <= o_frame_count + 16'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: directed table and sequence checks of the raster generator on a 14x7 timing
module tb_video_timing_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic stb = 1'b0;
    logic [15:0] x, y, fc, xn, yn, fcn;
    logic hs, vs, de, ls, fs, vb;
    logic hsn, vsn, den, lsn, fsn, vbn;
    logic [55:0] obs;
    int compared = 0;
    int mismatched = 0;
    logic [55:0] cap [0:196];
    int hs_cnt, vs_cnt, de_cnt;

    typedef struct {
        int          k;
        logic [15:0] x;
        logic [15:0] y;
        logic        de;
        logic        ls;
        logic        fs;
        logic        vb;
        logic [15:0] fc;
    } vec_t;
    vec_t tbl [12];

    always #5 clk = ~clk;

    video_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
                       .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b1)) dut (
        .i_clk(clk), .i_rst(rst), .i_pix_stb(stb), .o_x(x), .o_y(y), .o_h_sync(hs), .o_v_sync(vs),
        .o_de(de), .o_line_start(ls), .o_frame_start(fs), .o_vblank_start(vb), .o_frame_count(fc));

    video_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
                       .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b0)) dut_n (
        .i_clk(clk), .i_rst(rst), .i_pix_stb(stb), .o_x(xn), .o_y(yn), .o_h_sync(hsn), .o_v_sync(vsn),
        .o_de(den), .o_line_start(lsn), .o_frame_start(fsn), .o_vblank_start(vbn), .o_frame_count(fcn));

    assign obs = {x, y, hs, vs, de, ls, fs, vb, fc, hsn, vsn};

    function automatic logic [55:0] exp_vec(logic [15:0] ex, logic [15:0] ey, logic ehs, logic evs,
                                            logic ede, logic els, logic efs, logic evb, logic [15:0] efc);
        return {ex, ey, ehs, evs, ede, els, efs, evb, efc, ~ehs, ~evs};
    endfunction

    function automatic logic [55:0] model(int k, logic [15:0] efc);
        int p = k % 98;
        int mx = p % 14;
        int my = p / 14;
        return exp_vec(16'(mx), 16'(my), mx == 10 || mx == 11, my == 5, mx < 8 && my < 4,
                       mx == 0, mx == 0 && my == 0, mx == 0 && my == 4, efc);
    endfunction

    task automatic check(input string name, input int idx, input logic [55:0] act, input logic [55:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{0,   16'd0,  16'd0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd0};
        tbl[1]  = '{1,   16'd1,  16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[2]  = '{7,   16'd7,  16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[3]  = '{8,   16'd8,  16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[4]  = '{13,  16'd13, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[5]  = '{14,  16'd0,  16'd1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
        tbl[6]  = '{55,  16'd13, 16'd3, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[7]  = '{56,  16'd0,  16'd4, 1'b0, 1'b1, 1'b0, 1'b1, 16'd0};
        tbl[8]  = '{70,  16'd0,  16'd5, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
        tbl[9]  = '{97,  16'd13, 16'd6, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[10] = '{98,  16'd0,  16'd0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd1};
        tbl[11] = '{196, 16'd0,  16'd0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd2};

        // reset state, both sync polarities
        repeat (3) @(negedge clk);
        check("reset", 0, obs, exp_vec(0, 0, 0, 0, 0, 0, 0, 0, 0));

        // continuous strobe over two frames
        rst = 1'b0;
        stb = 1'b1;
        hs_cnt = 0; vs_cnt = 0; de_cnt = 0;
        for (int k = 0; k < 197; k++) begin
            @(negedge clk);
            cap[k] = obs;
            check("stream", k, obs, model(k, 16'(k / 98)));
            if (k < 98) begin
                hs_cnt += int'(hs);
                vs_cnt += int'(vs);
                de_cnt += int'(de);
            end
        end
        check("hs_count", 0, 56'(hs_cnt), 56'd14);
        check("vs_count", 0, 56'(vs_cnt), 56'd14);
        check("de_count", 0, 56'(de_cnt), 56'd32);
        for (int i = 0; i < 12; i++)
            check("table", tbl[i].k,
                  56'({cap[tbl[i].k][55:24], cap[tbl[i].k][21:18], cap[tbl[i].k][17:2]}),
                  56'({tbl[i].x, tbl[i].y, tbl[i].de, tbl[i].ls, tbl[i].fs, tbl[i].vb, tbl[i].fc}));

        // strobe every third clock: hold between strobes, one-clock pulses
        rst = 1'b1;
        stb = 1'b0;
        @(negedge clk);
        check("reset2", 0, obs, exp_vec(0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b0;
        for (int c = 0; c < 297; c++) begin
            logic [55:0] v;
            stb = (c % 3) == 0;
            @(negedge clk);
            v = model(c / 3, 16'((c / 3) / 98));
            if (c % 3 != 0)
                v[20:18] = 3'b000;
            check("slow", c, obs, v);
        end

        // reset mid-frame at (5,2) of the second frame, strobe held high
        rst = 1'b1;
        stb = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        stb = 1'b1;
        for (int k = 0; k < 132; k++) begin
            @(negedge clk);
            check("pre_rst", k, obs, model(k, 16'(k / 98)));
        end
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("mid_rst", i, obs, exp_vec(0, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        rst = 1'b0;
        for (int k = 0; k < 99; k++) begin
            @(negedge clk);
            check("post_rst", k, obs, model(k, 16'(k / 98)));
        end

        // frame counter wrap from 65535
        stb = 1'b0;
        force dut.o_frame_count = 16'hffff;
        @(negedge clk);
        release dut.o_frame_count;
        @(negedge clk);
        check("fc_preset", 0, 56'(fc), 56'hffff);
        stb = 1'b1;
        for (int k = 99; k < 197; k++) begin
            @(negedge clk);
            check("wrap", k, obs, model(k, (k < 196) ? 16'hffff : 16'd0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
